channel_readout_arbiter: RTL and testbench

//  Shares the single readout FIFO between g_NumChannels ChannelDigitalTop instances.

---
 rtl/channel_readout_arbiter_pkg.sv | 12 +
 rtl/channel_readout_arbiter_checkers.sv | 40 ++++
 rtl/channel_readout_arbiter_picker.sv | 26 ++
 rtl/channel_readout_arbiter.sv | 122 ++++++++++++
 tb/tb_channel_readout_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/channel_readout_arbiter_pkg.sv
// Shared types and constants for the channel readout arbiter slice.
package ReadoutPkg;
  typedef enum logic [1:0] {IDLE, XFER, FLUSH} t_ArbState;

  localparam int c_ChanIdWidth  = 4;
  localparam int c_HeaderWords  = 1;
  localparam int c_WordCntWidth = 7;

  function automatic logic [c_WordCntWidth-1:0] satInc(input logic [c_WordCntWidth-1:0] v);
    return (v == '1) ? v : v + c_WordCntWidth'(1);
  endfunction
endpackage

// File: rtl/channel_readout_arbiter_checkers.sv
// Protocol checkers for the arbiter: one-hot grant, no interleave, stall stability.
module ReadoutArbiterCheckers
  import ReadoutPkg::*;
#(
  parameter int g_NumChannels = 16,
  parameter int g_DataWidth   = 16
) (
  input logic                     clk,
  input logic                     reset,
  input logic [g_NumChannels-1:0] chanReady,
  input logic                     outValid,
  input logic [g_DataWidth-1:0]   outData,
  input logic                     outLast,
  input logic [c_ChanIdWidth-1:0] outChannelId,
  input logic                     outReady
);
  logic                     stallQ;
  logic [g_DataWidth-1:0]   heldData;
  logic                     inPkt;
  logic [c_ChanIdWidth-1:0] pktId;

  always_ff @(posedge clk) begin
    if (reset) begin
      stallQ   <= 1'b0;
      heldData <= '0;
      inPkt    <= 1'b0;
      pktId    <= '0;
    end else begin
      assert ($onehot0(chanReady));
      if (stallQ) assert (outValid && (outData == heldData));
      if (outValid && outReady && inPkt) assert (outChannelId == pktId);
      stallQ   <= outValid && !outReady;
      heldData <= outData;
      if (outValid && outReady) begin
        inPkt <= !outLast;
        pktId <= outChannelId;
      end
    end
  end
endmodule

// File: rtl/channel_readout_arbiter_picker.sv
// Round-robin picker: first requester after the pointer, wrapping; combinational, no state.
module rr_priority_picker
  import ReadoutPkg::*;
#(
  parameter int g_NumChannels = 16
) (
  input  logic [g_NumChannels-1:0] i_Req,
  input  logic [c_ChanIdWidth-1:0] i_Ptr,
  output logic [c_ChanIdWidth-1:0] o_Grant,
  output logic                     o_Any
);
  int cand;

  always_comb begin
    o_Grant = i_Ptr;
    cand    = 0;
    // Scan farthest-first so the nearest requester after the pointer is the last writer.
    for (int i = g_NumChannels; i >= 1; i--) begin
      cand = int'(i_Ptr) + i;
      if (cand >= g_NumChannels) cand = cand - g_NumChannels;
      if (i_Req[cand]) o_Grant = c_ChanIdWidth'(cand);
    end
  end

  assign o_Any = |i_Req;
endmodule

// File: rtl/channel_readout_arbiter.sv
// Round-robin packet arbiter into one readout FIFO; 1 arbitration cycle, then 1-cycle registered words.
// Backpressure: granted channel ready only while the output register is free; overlong tails are dropped.
module channel_readout_arbiter
  import ReadoutPkg::*;
#(
  parameter int g_NumChannels    = 16,
  parameter int g_DataWidth      = 16,
  parameter int g_MaxPacketWords = 64
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 i_MasterEnable,
  input  logic [g_NumChannels-1:0]             i_ChanValid,
  input  logic [g_NumChannels*g_DataWidth-1:0] i_ChanData,
  input  logic [g_NumChannels-1:0]             i_ChanLast,
  output logic [g_NumChannels-1:0]             o_ChanReady,
  output logic                                 o_Valid,
  output logic [g_DataWidth-1:0]               o_Data,
  output logic                                 o_Last,
  output logic [c_ChanIdWidth-1:0]             o_ChannelId,
  input  logic                                 i_Ready,
  output logic                                 o_Busy,
  output logic                                 o_OverlongErr,
  input  logic                                 i_ErrClear
);
  t_ArbState                 state;
  logic [c_ChanIdWidth-1:0]  grant;
  logic [c_ChanIdWidth-1:0]  rrPtr;
  logic [c_ChanIdWidth-1:0]  nextGrant;
  logic                      anyReq;
  logic [c_WordCntWidth-1:0] wordCnt;
  logic [c_WordCntWidth-1:0] wordNum;
  logic [g_DataWidth-1:0]    chanWords [g_NumChannels];
  logic                      grantReady;
  logic                      beat;
  logic                      hitMax;

  for (genvar k = 0; k < g_NumChannels; k++) begin : g_Unpack
    assign chanWords[k] = i_ChanData[k*g_DataWidth +: g_DataWidth];
  end

  rr_priority_picker #(
    .g_NumChannels(g_NumChannels)
  ) uPicker (
    .i_Req  (i_ChanValid),
    .i_Ptr  (rrPtr),
    .o_Grant(nextGrant),
    .o_Any  (anyReq)
  );

  always_comb begin
    grantReady = 1'b0;
    if (state == XFER)  grantReady = !o_Valid || i_Ready;
    if (state == FLUSH) grantReady = 1'b1;
    o_ChanReady        = '0;
    o_ChanReady[grant] = grantReady;
  end

  assign beat    = grantReady && i_ChanValid[grant];
  assign wordNum = satInc(wordCnt);
  assign hitMax  = (wordNum == c_WordCntWidth'(g_MaxPacketWords));
  assign o_Busy  = (state != IDLE) || o_Valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      grant         <= '0;
      rrPtr         <= c_ChanIdWidth'(g_NumChannels - 1);
      wordCnt       <= '0;
      o_Valid       <= 1'b0;
      o_Data        <= '0;
      o_Last        <= 1'b0;
      o_ChannelId   <= '0;
      o_OverlongErr <= 1'b0;
    end else begin
      if (o_Valid && i_Ready) begin
        o_Valid <= 1'b0;
        o_Last  <= 1'b0;
      end
      // A truncation in the same cycle overrides the clear below.
      if (i_ErrClear) o_OverlongErr <= 1'b0;
      case (state)
        IDLE: begin
          if (i_MasterEnable && anyReq) begin
            grant <= nextGrant;
            rrPtr <= nextGrant;
            state <= XFER;
          end
        end
        XFER: begin
          if (beat) begin
            o_Valid     <= 1'b1;
            o_Data      <= chanWords[grant];
            o_ChannelId <= grant;
            wordCnt     <= wordNum;
            if (i_ChanLast[grant]) begin
              o_Last  <= 1'b1;
              wordCnt <= '0;
              state   <= IDLE;
            end else if (hitMax) begin
              o_Last        <= 1'b1;
              o_OverlongErr <= 1'b1;
              state         <= FLUSH;
            end else begin
              o_Last <= 1'b0;
            end
          end
        end
        FLUSH: begin
          if (beat) begin
            wordCnt <= wordNum;
            if (i_ChanLast[grant]) begin
              wordCnt <= '0;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_channel_readout_arbiter.sv
// Bench for channel_readout_arbiter: packet queues per channel against a round-robin packet-order model.
`timescale 1ns/1ps

bind channel_readout_arbiter ReadoutArbiterCheckers #(
  .g_NumChannels(g_NumChannels),
  .g_DataWidth  (g_DataWidth)
) uCheckers (
  .clk         (clk),
  .reset       (reset),
  .chanReady   (o_ChanReady),
  .outValid    (o_Valid),
  .outData     (o_Data),
  .outLast     (o_Last),
  .outChannelId(o_ChannelId),
  .outReady    (i_Ready)
);

module tb_channel_readout_arbiter;
  import ReadoutPkg::*;

  localparam int N    = 16;
  localparam int DW   = 16;
  localparam int MAXW = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            i_MasterEnable = 1'b0;
  logic [N-1:0]    i_ChanValid = '0;
  logic [N*DW-1:0] i_ChanData = '0;
  logic [N-1:0]    i_ChanLast = '0;
  logic [N-1:0]    o_ChanReady;
  logic            o_Valid;
  logic [DW-1:0]   o_Data;
  logic            o_Last;
  logic [3:0]      o_ChannelId;
  logic            i_Ready = 1'b1;
  logic            o_Busy;
  logic            o_OverlongErr;
  logic            i_ErrClear = 1'b0;

  always #5 clk = ~clk;

  channel_readout_arbiter #(
    .g_NumChannels   (N),
    .g_DataWidth     (DW),
    .g_MaxPacketWords(MAXW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_MasterEnable(i_MasterEnable),
    .i_ChanValid   (i_ChanValid),
    .i_ChanData    (i_ChanData),
    .i_ChanLast    (i_ChanLast),
    .o_ChanReady   (o_ChanReady),
    .o_Valid       (o_Valid),
    .o_Data        (o_Data),
    .o_Last        (o_Last),
    .o_ChannelId   (o_ChannelId),
    .i_Ready       (i_Ready),
    .o_Busy        (o_Busy),
    .o_OverlongErr (o_OverlongErr),
    .i_ErrClear    (i_ErrClear)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [3:0]    id;
  } t_Beat;

  int            testsRun = 0;
  int            testsFailed = 0;
  logic [DW-1:0] chq [N][$];
  bit            chl [N][$];
  int            taken [N];
  logic [DW-1:0] mq [N][$];
  int            ml [N][$];
  t_Beat         expQ [$];
  int            modelPtr = N - 1;
  bit            expErr = 1'b0;
  int            readyMode = 0;
  bit            readyTog = 1'b0;
  bit            prevStall = 1'b0;
  logic [DW-1:0] prevData = '0;
  int            edges = 0;
  int            firstValidEdge = -1;
  int            outBeats = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pendingWords();
    int s;
    s = 0;
    for (int k = 0; k < N; k++) s += chq[k].size();
    return s;
  endfunction

  task automatic clearAll();
    for (int k = 0; k < N; k++) begin
      chq[k].delete();
      chl[k].delete();
      mq[k].delete();
      ml[k].delete();
      taken[k] = 0;
    end
    expQ.delete();
    modelPtr  = N - 1;
    prevStall = 1'b0;
    expErr    = 1'b0;
  endtask

  task automatic driveInputs();
    logic [N-1:0]    v;
    logic [N-1:0]    l;
    logic [N*DW-1:0] d;
    v = '0;
    l = '0;
    d = '0;
    for (int k = 0; k < N; k++) begin
      if (chq[k].size() > 0) begin
        v[k] = 1'b1;
        l[k] = chl[k][0];
        d[k*DW +: DW] = chq[k][0];
      end
    end
    i_ChanValid = v;
    i_ChanLast  = l;
    i_ChanData  = d;
    case (readyMode)
      1:       i_Ready = ($urandom_range(0, 3) != 0);
      2: begin
        readyTog = !readyTog;
        i_Ready  = readyTog;
      end
      default: i_Ready = 1'b1;
    endcase
  endtask

  task automatic loadPacket(input int ch, input int len, input bit seq);
    logic [DW-1:0] w;
    for (int i = 0; i < len; i++) begin
      if (i < c_HeaderWords) w = DW'(ch);
      else if (seq)          w = DW'(32'h0100 + i);
      else                   w = DW'($urandom);
      chq[ch].push_back(w);
      chl[ch].push_back(i == len - 1);
      mq[ch].push_back(w);
    end
    ml[ch].push_back(len);
  endtask

  // Packet-level model: every queued packet is presented continuously, so the output
  // is the packets in round-robin order, each cut to MAXW words with last on the cut.
  task automatic plan();
    int            c;
    int            len;
    bit            found;
    logic [DW-1:0] w;
    do begin
      found = 1'b0;
      for (int s = 1; s <= N; s++) begin
        c = (modelPtr + s) % N;
        if (!found && ml[c].size() > 0) begin
          found    = 1'b1;
          modelPtr = c;
        end
      end
      if (found) begin
        len = ml[modelPtr].pop_front();
        for (int i = 0; i < len; i++) begin
          w = mq[modelPtr].pop_front();
          if (i < MAXW)
            expQ.push_back('{data: w, last: (i == len - 1) || (i == MAXW - 1), id: 4'(modelPtr)});
        end
        if (len > MAXW) expErr = 1'b1;
      end
    end while (found);
  endtask

  task automatic runCycle();
    logic [N-1:0] fire;
    t_Beat        e;
    logic [DW-1:0] dw;
    bit           db;
    @(negedge clk);
    fire = i_ChanValid & o_ChanReady;
    check("ready_onehot0", 32'($onehot0(o_ChanReady)), 32'd1);
    if (prevStall) begin
      check("stall_valid_held", 32'(o_Valid), 32'd1);
      check("stall_data_held", 32'(o_Data), 32'(prevData));
    end
    if (o_Valid && firstValidEdge < 0) firstValidEdge = edges;
    if (o_Valid && i_Ready) begin
      outBeats++;
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $error("FAIL unexpected_beat: observed data %0h id %0d, expected no beat", o_Data, o_ChannelId);
      end else begin
        e = expQ.pop_front();
        check("beat_data", 32'(o_Data), 32'(e.data));
        check("beat_last", 32'(o_Last), 32'(e.last));
        check("beat_id", 32'(o_ChannelId), 32'(e.id));
      end
    end
    prevStall = o_Valid && !i_Ready;
    prevData  = o_Data;
    @(posedge clk);
    #1;
    edges++;
    for (int k = 0; k < N; k++) begin
      if (fire[k] && chq[k].size() > 0) begin
        dw = chq[k].pop_front();
        db = chl[k].pop_front();
        taken[k]++;
      end
    end
    driveInputs();
  endtask

  task automatic runUntilDone(input int budget, input string tag);
    int n;
    n = 0;
    while ((expQ.size() > 0 || pendingWords() > 0 || o_Busy) && n < budget) begin
      runCycle();
      n++;
    end
    if (n >= budget) begin
      testsRun++;
      testsFailed++;
      $error("FAIL %s_timeout: observed %0d cycles without completion, expected completion", tag, n);
    end
  endtask

  task automatic doReset();
    clearAll();
    driveInputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic pulseErrClear();
    i_ErrClear = 1'b1;
    @(posedge clk);
    #1;
    i_ErrClear = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: observed simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int np;
    int r;
    int len;

    // Reset values
    clearAll();
    driveInputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(o_Valid), 32'd0);
    check("rst_data", 32'(o_Data), 32'd0);
    check("rst_last", 32'(o_Last), 32'd0);
    check("rst_id", 32'(o_ChannelId), 32'd0);
    check("rst_ready", 32'(o_ChanReady), 32'd0);
    check("rst_busy", 32'(o_Busy), 32'd0);
    check("rst_err", 32'(o_OverlongErr), 32'd0);
    reset = 1'b0;
    i_MasterEnable = 1'b1;

    // 1: Ch0 17-word sequential packet, latency and count
    readyMode = 0;
    loadPacket(0, 17, 1'b1);
    plan();
    driveInputs();
    edges = 0;
    firstValidEdge = -1;
    outBeats = 0;
    runUntilDone(200, "t1");
    check("t1_first_valid_edge", 32'(firstValidEdge), 32'd2);
    check("t1_beat_count", 32'(outBeats), 32'd17);
    check("t1_err", 32'(o_OverlongErr), 32'd0);

    // 2: Ch1, Ch5, Ch15 together from reset, Ch1 again after
    doReset();
    readyMode = 1;
    loadPacket(1, $urandom_range(16, 30), 1'b0);
    loadPacket(5, $urandom_range(16, 30), 1'b0);
    loadPacket(15, $urandom_range(16, 30), 1'b0);
    loadPacket(1, $urandom_range(16, 30), 1'b0);
    plan();
    driveInputs();
    runUntilDone(1000, "t2");
    check("t2_err", 32'(o_OverlongErr), 32'd0);

    // 3: ready toggling every cycle
    readyMode = 2;
    loadPacket(7, 17, 1'b0);
    plan();
    driveInputs();
    runUntilDone(500, "t3");

    // 4: overlong packet truncated at MAXW, tail dropped, flag sticky until cleared
    readyMode = 1;
    loadPacket(3, 70, 1'b0);
    plan();
    driveInputs();
    runUntilDone(2000, "t4");
    check("t4_err_set", 32'(o_OverlongErr), 32'(expErr));
    check("t4_tail_consumed", 32'(taken[3]), 32'd70);
    pulseErrClear();
    check("t4_err_cleared", 32'(o_OverlongErr), 32'd0);
    expErr = 1'b0;

    // 5: enable falls mid-packet on Ch2 with Ch4 pending
    doReset();
    readyMode = 0;
    i_MasterEnable = 1'b1;
    loadPacket(2, 20, 1'b0);
    loadPacket(4, 18, 1'b0);
    plan();
    driveInputs();
    n = 0;
    while (taken[2] < 8 && n < 100) begin
      runCycle();
      n++;
    end
    i_MasterEnable = 1'b0;
    n = 0;
    while ((chq[2].size() > 0 || o_Busy) && n < 200) begin
      runCycle();
      n++;
    end
    check("t5_ch2_complete", 32'(taken[2]), 32'd20);
    for (int i = 0; i < 6; i++) begin
      runCycle();
      #1;
      check("t5_no_ready", 32'(o_ChanReady), 32'd0);
      check("t5_idle", 32'(o_Busy), 32'd0);
    end
    check("t5_ch4_untouched", 32'(taken[4]), 32'd0);
    i_MasterEnable = 1'b1;
    runUntilDone(300, "t5");
    check("t5_ch4_done", 32'(taken[4]), 32'd18);

    // 6: reset at word 10, then channel 0 has priority again
    readyMode = 0;
    loadPacket(1, 30, 1'b0);
    plan();
    driveInputs();
    n = 0;
    while (taken[1] < 10 && n < 100) begin
      runCycle();
      n++;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t6_valid", 32'(o_Valid), 32'd0);
    check("t6_last", 32'(o_Last), 32'd0);
    check("t6_data", 32'(o_Data), 32'd0);
    check("t6_id", 32'(o_ChannelId), 32'd0);
    check("t6_busy", 32'(o_Busy), 32'd0);
    check("t6_ready", 32'(o_ChanReady), 32'd0);
    reset = 1'b0;
    clearAll();
    loadPacket(1, 16, 1'b0);
    loadPacket(0, 16, 1'b0);
    plan();
    driveInputs();
    runUntilDone(300, "t6");

    // 7: random channel mixes, including single-word and overlong packets
    readyMode = 1;
    for (int round = 0; round < 3; round++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 2) == 0) begin
          np = $urandom_range(1, 2);
          for (int p = 0; p < np; p++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      len = 1;
            else if (r == 1) len = $urandom_range(65, 72);
            else             len = $urandom_range(16, 40);
            loadPacket(k, len, 1'b0);
          end
        end
      end
      plan();
      driveInputs();
      runUntilDone(8000, "t7");
      check("t7_err", 32'(o_OverlongErr), 32'(expErr));
      pulseErrClear();
      expErr = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
